inbuf_feeder: RTL and testbench

Upstream loader for the systolic array's input buffers. Accepts one tile of 8-bit operands as a valid/ready stream, distributes the elements round-robin across the per-row input-buffer lanes, then broadcasts a read strobe so all lanes drain into the array together. It sequences load and drain phases and flags framing and drain errors.

---
 rtl/systola_pkg.sv | 12 +
 rtl/inbuf_feeder_if.sv | 12 +
 rtl/feeder_rr_lane.sv | 41 ++++
 rtl/inbuf_feeder.sv | 93 +++++++++
 tb/tb_inbuf_feeder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/systola_pkg.sv
// Shared types and constants for the systolic-array front-end blocks.
package systola_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } feeder_state_t;

    localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/inbuf_feeder_if.sv
// Upstream element stream into the input-buffer feeder (valid/ready with tile framing).
interface inbuf_feeder_if #(
    parameter int DW = systola_pkg::DW_DEFAULT
) ();
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/feeder_rr_lane.sv
// Round-robin lane/column position within a tile: one-hot lane select and final-beat flag.
module feeder_rr_lane #(
    parameter int LANES = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [LANES-1:0] lane_sel,
    output logic             final_beat
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LW-1:0] lane;
    logic [CW-1:0] col;
    logic          last_lane;
    logic          last_col;

    // Explicit compares so non-power-of-two LANES/DEPTH wrap correctly.
    assign last_lane  = (lane == LW'(LANES - 1));
    assign last_col   = (col == CW'(DEPTH - 1));
    assign final_beat = last_lane && last_col;
    assign lane_sel   = LANES'(1) << lane;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            col  <= '0;
        end else if (adv) begin
            if (last_lane) begin
                lane <= '0;
                col  <= last_col ? '0 : col + 1'b1;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

endmodule

// File: rtl/inbuf_feeder.sv
// Loads one tile round-robin into the per-row input buffers, then drains them in lockstep.
// Define FEEDER_LAST_CHECK_EN to check s_last framing; otherwise err_last is tied low.
module inbuf_feeder
    import systola_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DEPTH  = 8,
    parameter int MAXPAD = 7,
    parameter int DW     = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    inbuf_feeder_if.slave    s,
    output logic [LANES-1:0] buf_write,
    output logic [DW-1:0]    buf_din,
    output logic             buf_read,
    input  logic [LANES-1:0] buf_empty,
    input  logic             array_ready,
    output logic             tile_done,
    output logic             err_last,
    output logic             err_drain
);
    localparam int DRAIN_LEN = DEPTH + MAXPAD;
    localparam int DCW       = $clog2(DRAIN_LEN + 1);

    feeder_state_t    state;
    logic [DCW-1:0]   drain_cnt;
    logic [LANES-1:0] lane_sel;
    logic             final_beat;
    logic             accept;
    logic             drain_end;

    // Handshake and read strobe depend only on state/array_ready, never on s_valid.
    assign s.s_ready = (state == LOAD) && !rst;
    assign buf_read  = (state == DRAIN) && array_ready;
    assign accept    = s.s_valid && s.s_ready;
    assign drain_end = buf_read && (drain_cnt == DCW'(DRAIN_LEN - 1));

    feeder_rr_lane #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_rr_lane (
        .clk        (clk),
        .rst        (rst),
        .adv        (accept),
        .lane_sel   (lane_sel),
        .final_beat (final_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            drain_cnt <= '0;
            buf_write <= '0;
            buf_din   <= '0;
            tile_done <= 1'b0;
            err_drain <= 1'b0;
        end else begin
            buf_write <= accept ? lane_sel : '0;
            if (accept) buf_din <= s.s_data;
            tile_done <= drain_end;
            // Every lane must be empty once the drain has completed.
            if (tile_done && !(&buf_empty)) err_drain <= 1'b1;

            case (state)
                LOAD: if (accept && final_beat) state <= WAIT;
                WAIT: if (array_ready) state <= DRAIN;
                DRAIN: begin
                    if (drain_end) begin
                        drain_cnt <= '0;
                        state     <= LOAD;
                    end else if (buf_read) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef FEEDER_LAST_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_last <= 1'b0;
        end else if (accept && (s.s_last != final_beat)) begin
            err_last <= 1'b1;
        end
    end
`else
    assign err_last = 1'b0;
`endif

endmodule

// File: tb/tb_inbuf_feeder.sv
// Directed bench for inbuf_feeder: table of per-beat vectors plus drain/stall/error/reset sequences.
module tb_inbuf_feeder;
    import systola_pkg::*;

    localparam int LANES     = 4;
    localparam int DEPTH     = 8;
    localparam int MAXPAD    = 7;
    localparam int DW        = 8;
    localparam int BEATS     = LANES * DEPTH;
    localparam int DRAIN_LEN = DEPTH + MAXPAD;
`ifdef FEEDER_LAST_CHECK_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [LANES-1:0] buf_write;
    logic [DW-1:0]    buf_din;
    logic             buf_read;
    logic [LANES-1:0] buf_empty;
    logic             array_ready;
    logic             tile_done;
    logic             err_last;
    logic             err_drain;

    inbuf_feeder_if #(.DW(DW)) s_if ();

    inbuf_feeder #(
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .MAXPAD (MAXPAD),
        .DW     (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s_if),
        .buf_write   (buf_write),
        .buf_din     (buf_din),
        .buf_read    (buf_read),
        .buf_empty   (buf_empty),
        .array_ready (array_ready),
        .tile_done   (tile_done),
        .err_last    (err_last),
        .err_drain   (err_drain)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]    data;
        logic             last;
        logic [LANES-1:0] exp_write;
    } vec_t;

    vec_t vecs[BEATS];
    int   checks = 0;
    int   errors = 0;
    bit   exp_err_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n_beats of the vector table; optional idle cycle before each beat.
    task automatic send_tile(input bit gap, input int extra_last, input bit last_on_final,
                             input int n_beats, output int cycles);
        cycles = 0;
        for (int k = 0; k < n_beats; k++) begin
            if (gap) begin
                s_if.s_valid = 1'b0;
                step();
                cycles++;
                check($sformatf("idle_write_b%0d", k + 1), buf_write, 0);
            end
            s_if.s_valid = 1'b1;
            s_if.s_data  = vecs[k].data;
            s_if.s_last  = (k + 1 == extra_last) || (vecs[k].last && last_on_final);
            check($sformatf("s_ready_b%0d", k + 1), s_if.s_ready, 1);
            if (LAST_EN && (s_if.s_last != vecs[k].last)) exp_err_last = 1'b1;
            step();
            cycles++;
            s_if.s_valid = 1'b0;
            s_if.s_last  = 1'b0;
            check($sformatf("lane_b%0d", k + 1), buf_write, vecs[k].exp_write);
            check($sformatf("din_b%0d", k + 1), buf_din, vecs[k].data);
            check($sformatf("err_last_b%0d", k + 1), err_last, exp_err_last);
        end
    endtask

    // Called in the first WAIT cycle; runs the drain and checks read count and tile_done timing.
    task automatic drain_tile(input string tag, input int stall_start, input int stall_len,
                              input logic [LANES-1:0] empty_at_done, input int exp_done_at,
                              input bit exp_err_drain);
        int reads = 0;
        int stall_reads = 0;
        int spurious = 0;
        int done_at = 0;
        bit stalled;
        check({tag, "_wait_s_ready"}, s_if.s_ready, 0);
        check({tag, "_wait_no_read"}, buf_read, 0);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'hAA;
        for (int i = 1; i <= 60; i++) begin
            step();
            stalled     = (i >= stall_start) && (i < stall_start + stall_len);
            array_ready = !stalled;
            buf_empty   = '0;
            #1;
            if (tile_done) begin
                done_at   = i;
                buf_empty = empty_at_done;
                break;
            end
            if (buf_read) begin
                reads++;
                if (stalled) stall_reads++;
            end
            if (buf_write != '0) spurious++;
        end
        s_if.s_valid = 1'b0;
        array_ready  = 1'b1;
        check({tag, "_reads"}, reads, DRAIN_LEN);
        check({tag, "_done_cycle"}, done_at, exp_done_at);
        check({tag, "_stall_reads"}, stall_reads, 0);
        check({tag, "_writes_outside_load"}, spurious, 0);
        step();
        buf_empty = '1;
        check({tag, "_done_one_cycle"}, tile_done, 0);
        check({tag, "_err_drain"}, err_drain, exp_err_drain);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < BEATS; k++) begin
            vecs[k].data      = DW'(k + 1);
            vecs[k].last      = (k == BEATS - 1);
            vecs[k].exp_write = LANES'(1) << (k % LANES);
        end
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;
        buf_empty    = '1;
        array_ready  = 1'b1;

        #2 rst = 1'b1;
        step();
        step();
        check("rst_s_ready", s_if.s_ready, 0);
        check("rst_buf_write", buf_write, 0);
        check("rst_buf_din", buf_din, 0);
        check("rst_buf_read", buf_read, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_err_last", err_last, 0);
        check("rst_err_drain", err_drain, 0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", s_if.s_ready, 1);

        // Back-to-back tile, no stalls.
        send_tile(1'b0, 0, 1'b1, BEATS, cyc);
        check("a_load_cycles", cyc, BEATS);
        drain_tile("a", 0, 0, '1, DRAIN_LEN + 1, 1'b0);

        // s_valid every other cycle.
        send_tile(1'b1, 0, 1'b1, BEATS, cyc);
        check("b_load_cycles", cyc, 2 * BEATS);
        drain_tile("b", 0, 0, '1, DRAIN_LEN + 1, 1'b0);

        // array_ready low for 3 cycles mid-drain.
        send_tile(1'b0, 0, 1'b1, BEATS, cyc);
        drain_tile("c", 5, 3, '1, DRAIN_LEN + 4, 1'b0);

        // Early s_last on beat 10, and a lane not empty at tile_done.
        send_tile(1'b0, 10, 1'b1, BEATS, cyc);
        check("d_load_cycles", cyc, BEATS);
        drain_tile("d", 0, 0, 4'b1011, DRAIN_LEN + 1, 1'b1);
        step();
        step();
        check("d_err_drain_sticky", err_drain, 1);
        check("d_err_last_sticky", err_last, exp_err_last);

        // Partial tile, then asynchronous reset mid-cycle.
        send_tile(1'b0, 0, 1'b1, 17, cyc);
        rst = 1'b1;
        #1;
        check("mid_rst_s_ready", s_if.s_ready, 0);
        check("mid_rst_buf_write", buf_write, 0);
        check("mid_rst_buf_din", buf_din, 0);
        check("mid_rst_buf_read", buf_read, 0);
        check("mid_rst_err_last", err_last, 0);
        check("mid_rst_err_drain", err_drain, 0);
        step();
        step();
        rst = 1'b0;
        exp_err_last = 1'b0;
        #1;

        // Fresh tile restarts at lane 0; final beat lacks s_last.
        send_tile(1'b0, 0, 1'b0, BEATS, cyc);
        drain_tile("e", 0, 0, '1, DRAIN_LEN + 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
